// File: rtl/player_motion.sv
// player_motion: per-frame player movement for a single sprite.
//   Decodes walk/jump intents from NUM_KEYS USB keycode slots, runs a
//   jump/gravity state machine and produces a saturating, wall-clamped
//   sprite position. All state updates on the frame_clk rising edge.
// Ports:
//   frame_clk  - frame-rate clock (vertical sync)
//   Reset      - asynchronous, active-high reset
//   keycodes   - NUM_KEYS packed 8-bit slots, 8'h00 = empty
//   Start      - sticky, set on the first frame with any key pressed
//   Pos_X/Y    - sprite position; Vel_Y - signed vertical velocity (neg = up)
//   On_Ground  - high in GROUND; Facing - 0 right, 1 left
//   State      - IDLE=0, GROUND=1, RISE=2, FALL=3
// Optional: define PLAYER_DOUBLE_JUMP_EN to allow one extra jump per airtime.
module player_motion #(
  parameter int NUM_KEYS   = 3,
  parameter int X_START    = 40,
  parameter int X_MIN      = 10,
  parameter int X_MAX      = 560,
  parameter int Y_MIN      = 10,
  parameter int GROUND_Y   = 250,
  parameter int WALK_SPEED = 5,
  parameter int JUMP_VEL   = 12,
  parameter int GRAVITY    = 1,
  parameter int MAX_FALL   = 10
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic [8*NUM_KEYS-1:0]   keycodes,
  output logic                    Start,
  output logic [9:0]              Pos_X,
  output logic [9:0]              Pos_Y,
  output logic signed [10:0]      Vel_Y,
  output logic                    On_Ground,
  output logic                    Facing,
  output logic [1:0]              State
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GROUND = 2'd1;
  localparam logic [1:0] RISE   = 2'd2;
  localparam logic [1:0] FALL   = 2'd3;

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_JUMP  = 8'h1A;

  localparam logic signed [10:0] X_MIN_S    = 11'(X_MIN);
  localparam logic signed [10:0] X_MAX_S    = 11'(X_MAX);
  localparam logic signed [10:0] WALK_S     = 11'(WALK_SPEED);
  localparam logic signed [10:0] JUMP_S     = 11'(JUMP_VEL);
  localparam logic signed [10:0] GRAV_S     = 11'(GRAVITY);
  localparam logic signed [10:0] MAX_FALL_S = 11'(MAX_FALL);
  localparam logic signed [11:0] Y_MIN_S    = 12'(Y_MIN);
  localparam logic signed [11:0] GROUND_S   = 12'(GROUND_Y);

  logic              start_q, start_d;
  logic [9:0]        pos_x_q, pos_x_d;
  logic [9:0]        pos_y_q, pos_y_d;
  logic signed [10:0] vel_y_q, vel_y_d;
  logic              facing_q, facing_d;
  logic [1:0]        state_q, state_d;
  logic              jump_held_q, jump_held_d;
`ifdef PLAYER_DOUBLE_JUMP_EN
  logic              air_tok_q, air_tok_d;
`endif

  logic              key_left, key_right, key_jump, any_key, jump_edge;
  logic signed [10:0] hvel, x_sum, vel_inc;
  logic [9:0]        x_sat;
  logic signed [11:0] y_sum;

  // Key decode: a keycode anywhere in the report counts, order irrelevant.
  always_comb begin
    key_left  = 1'b0;
    key_right = 1'b0;
    key_jump  = 1'b0;
    any_key   = 1'b0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (keycodes[8*k +: 8] == KEY_LEFT)  key_left  = 1'b1;
      if (keycodes[8*k +: 8] == KEY_RIGHT) key_right = 1'b1;
      if (keycodes[8*k +: 8] == KEY_JUMP)  key_jump  = 1'b1;
      if (keycodes[8*k +: 8] != 8'h00)     any_key   = 1'b1;
    end
    jump_edge = key_jump & ~jump_held_q;
  end

  // Horizontal step with wall saturation: the sprite stops at the wall.
  always_comb begin
    hvel = '0;
    if (key_left && !key_right) hvel = -WALK_S;
    if (key_right && !key_left) hvel = WALK_S;
    x_sum = $signed({1'b0, pos_x_q}) + hvel;
    if (x_sum < X_MIN_S)      x_sat = X_MIN_S[9:0];
    else if (x_sum > X_MAX_S) x_sat = X_MAX_S[9:0];
    else                      x_sat = x_sum[9:0];
  end

  // Vertical arithmetic uses the registered velocity, so a velocity change
  // shows up in position one frame later.
  always_comb begin
    y_sum   = $signed({2'b00, pos_y_q}) + $signed({vel_y_q[10], vel_y_q});
    vel_inc = vel_y_q + GRAV_S;
  end

  always_comb begin
    start_d     = start_q | any_key;
    state_d     = state_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    vel_y_d     = vel_y_q;
    facing_d    = facing_q;
    jump_held_d = key_jump;
`ifdef PLAYER_DOUBLE_JUMP_EN
    air_tok_d   = air_tok_q;
`endif

    // IDLE ignores keys entirely, including on the frame Start rises.
    if (state_q != IDLE) begin
      pos_x_d = x_sat;
      if (key_left ^ key_right) facing_d = key_left;
    end

    case (state_q)
      IDLE: begin
        if (!start_q && any_key) state_d = GROUND;
      end
      GROUND: begin
        pos_y_d = GROUND_S[9:0];
        vel_y_d = '0;
        if (jump_edge) begin
          vel_y_d = -JUMP_S;
          state_d = RISE;
        end
      end
      RISE: begin
        if (y_sum <= Y_MIN_S) begin
          pos_y_d = Y_MIN_S[9:0];
          vel_y_d = '0;
          state_d = FALL;
        end else begin
          pos_y_d = y_sum[9:0];
          vel_y_d = vel_inc;
          if (!vel_inc[10]) state_d = FALL;
        end
      end
      default: begin // FALL
        if (y_sum >= GROUND_S) begin
          pos_y_d = GROUND_S[9:0];
          vel_y_d = '0;
          state_d = GROUND;
        end else begin
          pos_y_d = y_sum[9:0];
          vel_y_d = (vel_inc > MAX_FALL_S) ? MAX_FALL_S : vel_inc;
        end
      end
    endcase

`ifdef PLAYER_DOUBLE_JUMP_EN
    // A landing in the same frame wins over an air jump.
    if ((state_q == RISE || state_q == FALL) && jump_edge && air_tok_q &&
        state_d != GROUND) begin
      vel_y_d   = -JUMP_S;
      state_d   = RISE;
      air_tok_d = 1'b0;
    end
    if (state_d == GROUND) air_tok_d = 1'b1;
`endif
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      start_q     <= 1'b0;
      pos_x_q     <= 10'(X_START);
      pos_y_q     <= 10'(GROUND_Y);
      vel_y_q     <= '0;
      facing_q    <= 1'b0;
      state_q     <= IDLE;
      jump_held_q <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
      air_tok_q   <= 1'b1;
`endif
    end else begin
      start_q     <= start_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      vel_y_q     <= vel_y_d;
      facing_q    <= facing_d;
      state_q     <= state_d;
      jump_held_q <= jump_held_d;
`ifdef PLAYER_DOUBLE_JUMP_EN
      air_tok_q   <= air_tok_d;
`endif
    end
  end

  assign Start     = start_q;
  assign Pos_X     = pos_x_q;
  assign Pos_Y     = pos_y_q;
  assign Vel_Y     = vel_y_q;
  assign Facing    = facing_q;
  assign State     = state_q;
  assign On_Ground = (state_q == GROUND);

endmodule

// File: tb/tb_player_motion.sv
module tb_player_motion;

  logic               frame_clk;
  logic               Reset;
  logic [23:0]        keycodes;
  logic               Start;
  logic [9:0]         Pos_X, Pos_Y;
  logic signed [10:0] Vel_Y;
  logic               On_Ground, Facing;
  logic [1:0]         State;

  int pass_cnt  = 0;
  int total_cnt = 0;

  player_motion dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycodes  (keycodes),
    .Start     (Start),
    .Pos_X     (Pos_X),
    .Pos_Y     (Pos_Y),
    .Vel_Y     (Vel_Y),
    .On_Ground (On_Ground),
    .Facing    (Facing),
    .State     (State)
  );

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  // Advance n frames; outputs are then sampled 1 ns after the edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge frame_clk);
      #1;
    end
  endtask

  task automatic test_reset();
    keycodes = 24'h0;
    Reset = 1'b1;
    #12 Reset = 1'b0;
    step(5);
    total_cnt++;
    if (State !== 2'd0) $display("FAIL reset_state got %0d want 0", State); else pass_cnt++;
    total_cnt++;
    if (Pos_X !== 10'd40 || Pos_Y !== 10'd250)
      $display("FAIL reset_pos got (%0d,%0d) want (40,250)", Pos_X, Pos_Y); else pass_cnt++;
    total_cnt++;
    if (Start !== 1'b0 || Vel_Y !== 11'sd0 || Facing !== 1'b0 || On_Ground !== 1'b0)
      $display("FAIL reset_misc got start=%b vel=%0d face=%b gnd=%b want 0,0,0,0",
               Start, Vel_Y, Facing, On_Ground); else pass_cnt++;
  endtask

  task automatic test_start();
    keycodes = {8'h00, 8'h00, 8'h07};
    step(1);
    total_cnt++;
    if (Start !== 1'b1 || State !== 2'd1 || Pos_X !== 10'd40)
      $display("FAIL start_frame got start=%b state=%0d x=%0d want 1,1,40",
               Start, State, Pos_X); else pass_cnt++;
    step(1);
    total_cnt++;
    if (Pos_X !== 10'd45 || Facing !== 1'b0 || On_Ground !== 1'b1)
      $display("FAIL start_first_move got x=%0d face=%b gnd=%b want 45,0,1",
               Pos_X, Facing, On_Ground); else pass_cnt++;
  endtask

  task automatic test_walk();
    keycodes = {8'h04, 8'h07, 8'h00};
    step(2);
    total_cnt++;
    if (Pos_X !== 10'd45) $display("FAIL walk_both got x=%0d want 45", Pos_X); else pass_cnt++;
    keycodes = {8'h04, 8'h00, 8'h00};
    step(1);
    total_cnt++;
    if (Pos_X !== 10'd40 || Facing !== 1'b1)
      $display("FAIL walk_left got x=%0d face=%b want 40,1", Pos_X, Facing); else pass_cnt++;
    step(1);
    total_cnt++;
    if (Pos_X !== 10'd35) $display("FAIL walk_left2 got x=%0d want 35", Pos_X); else pass_cnt++;
    step(8);
    total_cnt++;
    if (Pos_X !== 10'd10) $display("FAIL walk_sat_min got x=%0d want 10", Pos_X); else pass_cnt++;
    keycodes = {8'h00, 8'h07, 8'h00};
    step(120);
    total_cnt++;
    if (Pos_X !== 10'd560 || Facing !== 1'b0)
      $display("FAIL walk_sat_max got x=%0d face=%b want 560,0", Pos_X, Facing); else pass_cnt++;
  endtask

  // Single jump; left held during the whole flight (26 airborne frames).
  task automatic test_jump();
    keycodes = {8'h00, 8'h00, 8'h1A};
    step(1);
    total_cnt++;
    if (State !== 2'd2 || Vel_Y !== -11'sd12 || Pos_Y !== 10'd250)
      $display("FAIL jump_launch got state=%0d vel=%0d y=%0d want 2,-12,250",
               State, Vel_Y, Pos_Y); else pass_cnt++;
    keycodes = {8'h04, 8'h00, 8'h00};
    step(1);
    total_cnt++;
    if (Pos_Y !== 10'd238 || Vel_Y !== -11'sd11 || State !== 2'd2)
      $display("FAIL jump_rise1 got y=%0d vel=%0d state=%0d want 238,-11,2",
               Pos_Y, Vel_Y, State); else pass_cnt++;
    step(1);
    total_cnt++;
    if (Pos_Y !== 10'd227 || Vel_Y !== -11'sd10)
      $display("FAIL jump_rise2 got y=%0d vel=%0d want 227,-10", Pos_Y, Vel_Y); else pass_cnt++;
    step(10);
    total_cnt++;
    if (State !== 2'd3 || Pos_Y !== 10'd172 || Vel_Y !== 11'sd0)
      $display("FAIL jump_peak got state=%0d y=%0d vel=%0d want 3,172,0",
               State, Pos_Y, Vel_Y); else pass_cnt++;
    step(13);
    total_cnt++;
    if (State !== 2'd3 || Pos_Y !== 10'd247 || Vel_Y !== 11'sd10)
      $display("FAIL jump_fall_cap got state=%0d y=%0d vel=%0d want 3,247,10",
               State, Pos_Y, Vel_Y); else pass_cnt++;
    step(1);
    total_cnt++;
    if (State !== 2'd1 || Pos_Y !== 10'd250 || Vel_Y !== 11'sd0 || On_Ground !== 1'b1)
      $display("FAIL jump_land got state=%0d y=%0d vel=%0d gnd=%b want 1,250,0,1",
               State, Pos_Y, Vel_Y, On_Ground); else pass_cnt++;
    total_cnt++;
    if (Pos_X !== 10'd430 || Facing !== 1'b1)
      $display("FAIL jump_air_walk got x=%0d face=%b want 430,1", Pos_X, Facing); else pass_cnt++;
  endtask

  task automatic test_hold_jump();
    keycodes = {8'h00, 8'h00, 8'h1A};
    step(1);
    total_cnt++;
    if (State !== 2'd2) $display("FAIL hold_launch got state=%0d want 2", State); else pass_cnt++;
    step(26);
    total_cnt++;
    if (State !== 2'd1 || Pos_Y !== 10'd250)
      $display("FAIL hold_land got state=%0d y=%0d want 1,250", State, Pos_Y); else pass_cnt++;
    step(3);
    total_cnt++;
    if (State !== 2'd1) $display("FAIL hold_no_retrigger got state=%0d want 1", State); else pass_cnt++;
    keycodes = 24'h0;
    step(1);
    keycodes = {8'h00, 8'h1A, 8'h00};
    step(1);
    total_cnt++;
    if (State !== 2'd2) $display("FAIL hold_repress got state=%0d want 2", State); else pass_cnt++;
  endtask

  task automatic test_reset_mid_jump();
    step(1);
    total_cnt++;
    if (State !== 2'd2 || Pos_Y !== 10'd238)
      $display("FAIL rst_pre got state=%0d y=%0d want 2,238", State, Pos_Y); else pass_cnt++;
    #3 Reset = 1'b1;
    #1;
    total_cnt++;
    if (State !== 2'd0 || Pos_X !== 10'd40 || Pos_Y !== 10'd250 || Vel_Y !== 11'sd0 || Start !== 1'b0)
      $display("FAIL rst_async got state=%0d pos=(%0d,%0d) vel=%0d start=%b want 0,(40,250),0,0",
               State, Pos_X, Pos_Y, Vel_Y, Start); else pass_cnt++;
    #2 Reset = 1'b0;
    keycodes = 24'h0;
    step(1);
    total_cnt++;
    if (State !== 2'd0 || Start !== 1'b0)
      $display("FAIL rst_rearm got state=%0d start=%b want 0,0", State, Start); else pass_cnt++;
    keycodes = {8'h00, 8'h00, 8'h1A};
    step(1);
    total_cnt++;
    if (State !== 2'd1 || Start !== 1'b1 || Pos_X !== 10'd40)
      $display("FAIL rst_restart got state=%0d start=%b x=%0d want 1,1,40",
               State, Start, Pos_X); else pass_cnt++;
    step(1);
    total_cnt++;
    if (State !== 2'd1 || Pos_Y !== 10'd250)
      $display("FAIL rst_idle_key_ignored got state=%0d y=%0d want 1,250", State, Pos_Y); else pass_cnt++;
  endtask

  task automatic test_air_jump();
    keycodes = 24'h0;
    step(1);
    keycodes = {8'h1A, 8'h00, 8'h00};
    step(1);
    keycodes = 24'h0;
    step(12);
    total_cnt++;
    if (State !== 2'd3 || Pos_Y !== 10'd172)
      $display("FAIL air_peak got state=%0d y=%0d want 3,172", State, Pos_Y); else pass_cnt++;
    keycodes = {8'h1A, 8'h00, 8'h00};
    step(1);
`ifdef PLAYER_DOUBLE_JUMP_EN
    total_cnt++;
    if (State !== 2'd2 || Vel_Y !== -11'sd12 || Pos_Y !== 10'd172)
      $display("FAIL air_second got state=%0d vel=%0d y=%0d want 2,-12,172",
               State, Vel_Y, Pos_Y); else pass_cnt++;
    keycodes = 24'h0;
    step(1);
    keycodes = {8'h1A, 8'h00, 8'h00};
    step(1);
    total_cnt++;
    if (State !== 2'd2 || Vel_Y !== -11'sd10 || Pos_Y !== 10'd149)
      $display("FAIL air_third_ignored got state=%0d vel=%0d y=%0d want 2,-10,149",
               State, Vel_Y, Pos_Y); else pass_cnt++;
`else
    total_cnt++;
    if (State !== 2'd3 || Vel_Y !== 11'sd1 || Pos_Y !== 10'd172)
      $display("FAIL air_ignored got state=%0d vel=%0d y=%0d want 3,1,172",
               State, Vel_Y, Pos_Y); else pass_cnt++;
    keycodes = 24'h0;
    step(1);
    keycodes = {8'h1A, 8'h00, 8'h00};
    step(1);
    total_cnt++;
    if (State !== 2'd3 || Vel_Y !== 11'sd3 || Pos_Y !== 10'd175)
      $display("FAIL air_ignored2 got state=%0d vel=%0d y=%0d want 3,3,175",
               State, Vel_Y, Pos_Y); else pass_cnt++;
`endif
  endtask

  initial begin
    Reset    = 1'b1;
    keycodes = 24'h0;
    test_reset();
    test_start();
    test_walk();
    test_jump();
    test_hold_jump();
    test_reset_mid_jump();
    test_air_jump();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/player_motion.md
Name: player_motion

Overview:
- Parametrised successor to the single-player ball movement logic.
- Resolves keycodes from NUM_KEYS USB report slots into walk/jump intents.
- Runs a per-frame jump/gravity state machine; produces a saturating, bounds-clamped sprite position.
- Sits between the USB keycode registers and the sprite/collision drawing logic; updates once per frame_clk rising edge (vertical sync).

Parameters:
- NUM_KEYS, 3, number of 8-bit keycode slots examined.
- X_START, 40, X position after reset.
- X_MIN, 10, lowest legal X.
- X_MAX, 560, highest legal X.
- Y_MIN, 10, ceiling; highest point on screen (smallest Y).
- GROUND_Y, 250, floor Y; also the Y position after reset.
- WALK_SPEED, 5, horizontal pixels per frame.
- JUMP_VEL, 12, initial upward speed magnitude in pixels per frame.
- GRAVITY, 1, added to Y velocity each airborne frame.
- MAX_FALL, 10, maximum downward velocity.

Ports:
- frame_clk  in  1  frame-rate clock.
- Reset  in  1  asynchronous, active-high reset.
- keycodes  in  8*NUM_KEYS  slot k occupies bits [8k+7:8k]; 8'h00 means empty.
- Start  out  1  latched high on the first frame any slot is nonzero.
- Pos_X  out  10  sprite X position.
- Pos_Y  out  10  sprite Y position.
- Vel_Y  out  11  signed Y velocity; negative means up.
- On_Ground  out  1  high in state GROUND.
- Facing  out  1  0 = right, 1 = left.
- State  out  2  IDLE=0, GROUND=1, RISE=2, FALL=3.

Behaviour:
- Reset is asynchronous, active-high. Reset values:
  - Start=0, Pos_X=X_START, Pos_Y=GROUND_Y, Vel_Y=0, Facing=0, State=IDLE.
  - Internal jump-held flag cleared.
- Key decode, combinational, over all slots:
  - left = any slot 8'h04; right = any slot 8'h07; jump = any slot 8'h1A.
  - Slot order is irrelevant.
- Horizontal velocity:
  - left only → -WALK_SPEED. right only → +WALK_SPEED. Both or neither → 0.
  - Facing updates only when exactly one direction is held.
- Horizontal position:
  - Next X is computed in 11-bit signed arithmetic.
  - The result saturates to X_MIN or X_MAX. The sprite stops at the wall; the move is not rejected.
- Jump edge:
  - jump_edge = jump AND NOT jump_held; jump_held <= jump every frame.
  - Holding W never re-triggers a jump.
- State machine, one transition per frame:
  - IDLE: Pos_X, Pos_Y, Vel_Y frozen. Go to GROUND on the frame Start rises. Keys in that frame are ignored.
  - GROUND: Pos_Y=GROUND_Y, Vel_Y=0, horizontal motion applied. On jump_edge: Vel_Y <= -JUMP_VEL, go to RISE.
  - RISE:
    - Pos_Y <= Pos_Y+Vel_Y, saturated at Y_MIN.
    - If the ceiling is hit, Vel_Y <= 0 and go to FALL.
    - Otherwise Vel_Y <= Vel_Y+GRAVITY, and go to FALL when the new Vel_Y >= 0.
  - FALL:
    - Vel_Y <= min(Vel_Y+GRAVITY, MAX_FALL).
    - Pos_Y <= Pos_Y+Vel_Y, using the pre-update velocity.
    - If Pos_Y+Vel_Y >= GROUND_Y: Pos_Y <= GROUND_Y, Vel_Y <= 0, go to GROUND.
- Horizontal motion is applied in GROUND, RISE and FALL.
- Position uses the current registered velocity, so a velocity change takes effect one frame later. There is exactly one frame of latency from a key press to position change.
- Reset mid-jump returns immediately to the reset values, including IDLE. Start must be re-armed.
- Start never falls except on reset.

Optional Feature:
- Macro: PLAYER_DOUBLE_JUMP_EN.
- Defined:
  - In RISE or FALL, one jump_edge per airtime reloads Vel_Y <= -JUMP_VEL and forces RISE.
  - The air-jump token is restored on entering GROUND.
- Undefined: jump_edge is ignored while airborne; the token logic is absent.

Test Plan:
- Reset, then keycodes all 0 for 5 frames → State=0, Pos=(40,250), Start=0. Set slot0=8'h07 → next frame Start=1, State=1, Pos_X still 40. Following frame Pos_X=45.
- In GROUND, hold slot2=8'h04 and slot1=8'h07 → Pos_X constant. Release 8'h07 → Pos_X decreases by 5 per frame, Facing=1. Hold 8'h04 long enough → Pos_X saturates at exactly 10.
- From GROUND, pulse 8'h1A for one frame → State=2, Vel_Y=-12, then -11, -10 …; peak at Pos_Y=250-78=172; State=3 when Vel_Y reaches 0. Lands at Pos_Y=250, State=1, On_Ground=1.
- Hold 8'h1A continuously across a landing → no second jump; State stays 1 until W is released and re-pressed.
- Pulse Reset during RISE → same edge: State=0, Pos=(40,250), Vel_Y=0, Start=0.
- With PLAYER_DOUBLE_JUMP_EN: press W, release, press again while in FALL → Vel_Y=-12, State=2. A third press in the air is ignored.
